i2c_reg_bank: RTL and testbench

I2C_REG_BANK -- requirements
Module: i2c_reg_bank

---
 rtl/i2c_reg_pkg.sv | 37 +++
 rtl/i2c_reg_addr_decode.sv | 42 ++++
 rtl/i2c_reg_bank.sv | 115 +++++++++++
 tb/tb_i2c_reg_bank.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_pkg.sv
// Shared constants and types for the I2C register bank: address map,
// STATUS bit positions, default ID and the register-select encoding.
package i2c_reg_pkg;

  localparam logic [15:0] ID_VALUE_DEFAULT = 16'hA5C2;

  localparam logic [7:0] ADDR_ID           = 8'h00;
  localparam logic [7:0] ADDR_CTRL         = 8'h01;
  localparam logic [7:0] ADDR_STATUS       = 8'h02;
  localparam logic [7:0] ADDR_IRQ_MASK     = 8'h03;
  localparam logic [7:0] ADDR_WR_COUNT     = 8'h04;
  localparam logic [7:0] ADDR_HW_STATUS    = 8'h05;
  localparam logic [7:0] ADDR_SCRATCH_BASE = 8'h10;

  localparam int unsigned STAT_ERR_ADDR = 0;
  localparam int unsigned STAT_ERR_RO   = 1;
  localparam int unsigned STAT_HW_EVT   = 2;
  localparam int unsigned STAT_W        = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ID,
    SEL_CTRL,
    SEL_STATUS,
    SEL_IRQ_MASK,
    SEL_WR_COUNT,
    SEL_HW_STATUS,
    SEL_SCRATCH
  } reg_sel_e;

  // Index width for the scratch array; at least one bit so a single
  // scratch register still has a legal index.
  function automatic int unsigned scratch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_reg_addr_decode.sv
// Combinational address decoder: maps a bridge address onto a register
// select, scratch index and the RO / unmapped qualifiers.
module i2c_reg_addr_decode
  import i2c_reg_pkg::*;
#(
  parameter int unsigned NUM_SCRATCH = 8,
  parameter int unsigned SIDX_W      = scratch_idx_w(NUM_SCRATCH)
) (
  input  logic [7:0]        addr_i,
  output reg_sel_e          sel_o,
  output logic [SIDX_W-1:0] scratch_idx_o,
  output logic              is_ro_o,
  output logic              is_unmapped_o
);

  localparam logic [7:0] SCRATCH_LAST =
    8'(32'(ADDR_SCRATCH_BASE) + NUM_SCRATCH - 32'd1);

  // Fixed registers first, then the scratch window, everything else unmapped.
  always_comb begin
    sel_o         = SEL_NONE;
    scratch_idx_o = addr_i[SIDX_W-1:0];
    is_ro_o       = 1'b0;
    is_unmapped_o = 1'b0;
    case (addr_i)
      ADDR_ID:        begin sel_o = SEL_ID;        is_ro_o = 1'b1; end
      ADDR_CTRL:      sel_o = SEL_CTRL;
      ADDR_STATUS:    sel_o = SEL_STATUS;
      ADDR_IRQ_MASK:  sel_o = SEL_IRQ_MASK;
      ADDR_WR_COUNT:  begin sel_o = SEL_WR_COUNT;  is_ro_o = 1'b1; end
      ADDR_HW_STATUS: begin sel_o = SEL_HW_STATUS; is_ro_o = 1'b1; end
      default: begin
        if (addr_i >= ADDR_SCRATCH_BASE && addr_i <= SCRATCH_LAST) begin
          sel_o = SEL_SCRATCH;
        end else begin
          is_unmapped_o = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the I2C frame bridge: ID, CTRL, W1C STATUS,
// IRQ_MASK, saturating write counter, live HW status and scratch registers.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter logic [15:0] ID_VALUE    = ID_VALUE_DEFAULT,
  parameter int unsigned NUM_SCRATCH = 8
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] wdata_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  output logic [15:0] rdata_o,
  input  logic [15:0] hw_status_i,
  input  logic        hw_event_i,
  output logic [15:0] ctrl_o,
  output logic        irq_o
);

  localparam int unsigned SIDX_W = scratch_idx_w(NUM_SCRATCH);

  reg_sel_e          sel;
  logic [SIDX_W-1:0] scratch_idx;
  logic              is_ro;
  logic              is_unmapped;

  logic [15:0]       ctrl;
  logic [STAT_W-1:0] status;
  logic [2:0]        irq_mask;
  logic [15:0]       wr_count;
  logic [15:0]       scratch [NUM_SCRATCH];

  logic              wr_accept;
  logic [STAT_W-1:0] status_set;
  logic [STAT_W-1:0] status_clr;
  logic [STAT_W-1:0] status_nxt;
  logic [15:0]       wr_count_nxt;
  logic [15:0]       rd_val;

  i2c_reg_addr_decode #(
    .NUM_SCRATCH (NUM_SCRATCH),
    .SIDX_W      (SIDX_W)
  ) u_decode (
    .addr_i        (addr_i),
    .sel_o         (sel),
    .scratch_idx_o (scratch_idx),
    .is_ro_o       (is_ro),
    .is_unmapped_o (is_unmapped)
  );

  // Next-state for STATUS and WR_COUNT plus the read mux; set wins over W1C.
  always_comb begin
    wr_accept  = wr_en_i & ~is_ro & ~is_unmapped;

    status_set                = '0;
    status_set[STAT_ERR_ADDR] = (wr_en_i | rd_en_i) & is_unmapped;
    status_set[STAT_ERR_RO]   = wr_en_i & is_ro;
    status_set[STAT_HW_EVT]   = hw_event_i;

    status_clr = (wr_en_i && sel == SEL_STATUS) ? wdata_i[STAT_W-1:0] : '0;
    status_nxt = (status & ~status_clr) | status_set;

    wr_count_nxt = (wr_accept && wr_count != '1) ? wr_count + 16'd1 : wr_count;

    rd_val = '0;
    case (sel)
      SEL_ID:        rd_val = ID_VALUE;
      SEL_CTRL:      rd_val = ctrl;
      SEL_STATUS:    rd_val = {{(16-STAT_W){1'b0}}, status};
      SEL_IRQ_MASK:  rd_val = {13'd0, irq_mask};
      SEL_WR_COUNT:  rd_val = wr_count;
      SEL_HW_STATUS: rd_val = hw_status_i;
      SEL_SCRATCH:   rd_val = scratch[scratch_idx];
      default:       rd_val = '0;
    endcase
  end

  // Register state updates; WR_COUNT reloads its next value every cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl     <= '0;
      status   <= '0;
      irq_mask <= '0;
      wr_count <= '0;
      for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      status   <= status_nxt;
      wr_count <= wr_count_nxt;
      if (wr_en_i) begin
        case (sel)
          SEL_CTRL:     ctrl     <= wdata_i;
          SEL_IRQ_MASK: irq_mask <= wdata_i[2:0];
          SEL_SCRATCH:  scratch[scratch_idx] <= wdata_i;
          default:      ;
        endcase
      end
    end
  end

  // Registered read data and interrupt, both sampled from current state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_o <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (rd_en_i) rdata_o <= rd_val;
      irq_o <= ctrl[0] & |(status & irq_mask);
    end
  end

  assign ctrl_o = ctrl;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed self-checking bench for i2c_reg_bank.
module tb_i2c_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] rdata;
  logic [15:0] hw_status;
  logic        hw_event;
  logic [15:0] ctrl;
  logic        irq;

  int unsigned checks;
  int unsigned failures;

  i2c_reg_bank #(
    .ID_VALUE    (16'hA5C2),
    .NUM_SCRATCH (8)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .wr_en_i     (wr_en),
    .rd_en_i     (rd_en),
    .rdata_o     (rdata),
    .hw_status_i (hw_status),
    .hw_event_i  (hw_event),
    .ctrl_o      (ctrl),
    .irq_o       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
    @(negedge clk);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_eq(tag, rdata, exp);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    addr      = '0;
    wdata     = '0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    hw_status = '0;
    hw_event  = 1'b0;

    #1;
    check_eq("rst_rdata", rdata, 16'h0000);
    check_eq("rst_ctrl",  ctrl,  16'h0000);
    check_eq("rst_irq",   {15'd0, irq}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    rd_check("id",        8'h00, 16'hA5C2);
    rd_check("ctrl_rst",  8'h01, 16'h0000);

    wr(8'h12, 16'hBEEF);
    rd_check("scr12",     8'h12, 16'hBEEF);
    rd_check("wrcnt1",    8'h04, 16'h0001);

    wr(8'h00, 16'h1234);
    rd_check("id_ro",     8'h00, 16'hA5C2);
    rd_check("st_err_ro", 8'h02, 16'h0002);
    rd_check("unmap7f",   8'h7F, 16'h0000);
    rd_check("st_both",   8'h02, 16'h0003);
    wr(8'h02, 16'h0001);
    rd_check("st_w1c0",   8'h02, 16'h0002);
    wr(8'h02, 16'h0002);
    rd_check("st_w1c1",   8'h02, 16'h0000);

    wr(8'h17, 16'h1717);
    rd_check("scr_last",  8'h17, 16'h1717);
    wr(8'h18, 16'hFFFF);
    rd_check("st_unmap18", 8'h02, 16'h0001);
    wr(8'h02, 16'hFFFF);
    rd_check("st_clrall", 8'h02, 16'h0000);

    hw_status = 16'h3C5A;
    rd_check("hwstat",    8'h05, 16'h3C5A);

    wr(8'h03, 16'hFFFC);
    rd_check("mask_rd",   8'h03, 16'h0004);
    wr(8'h01, 16'h0001);
    check_eq("ctrl_o",    ctrl, 16'h0001);
    check_eq("irq_idle",  {15'd0, irq}, 16'h0000);

    @(negedge clk);
    hw_event = 1'b1;
    @(negedge clk);
    hw_event = 1'b0;
    check_eq("irq_lag",   {15'd0, irq}, 16'h0000);
    @(negedge clk);
    check_eq("irq_set",   {15'd0, irq}, 16'h0001);

    @(negedge clk);
    addr     = 8'h02;
    wdata    = 16'h0004;
    wr_en    = 1'b1;
    hw_event = 1'b1;
    @(negedge clk);
    wr_en    = 1'b0;
    hw_event = 1'b0;
    rd_check("st_setwins", 8'h02, 16'h0004);
    check_eq("irq_hold",  {15'd0, irq}, 16'h0001);
    wr(8'h02, 16'h0004);
    rd_check("st_evtclr", 8'h02, 16'h0000);
    check_eq("irq_clr",   {15'd0, irq}, 16'h0000);
    rd_check("wrcnt9",    8'h04, 16'h0009);

    @(negedge clk);
    force dut.wr_count = 16'hFFFE;
    @(negedge clk);
    release dut.wr_count;
    rd_check("wrcnt_pre", 8'h04, 16'hFFFE);
    wr(8'h11, 16'h0001);
    wr(8'h11, 16'h0002);
    wr(8'h11, 16'h0003);
    rd_check("wrcnt_sat", 8'h04, 16'hFFFF);

    @(negedge clk);
    addr  = 8'h10;
    wdata = 16'h5555;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_eq("rw_old",    rdata, 16'h0000);
    rd_check("rw_new",    8'h10, 16'h5555);

    @(negedge clk);
    hw_event = 1'b1;
    @(negedge clk);
    hw_event = 1'b0;
    @(negedge clk);
    check_eq("irq_pre_rst", {15'd0, irq}, 16'h0001);

    #2;
    rst_n = 1'b0;
    addr  = 8'h00;
    rd_en = 1'b1;
    #1;
    check_eq("mrst_rdata", rdata, 16'h0000);
    check_eq("mrst_ctrl",  ctrl,  16'h0000);
    check_eq("mrst_irq",   {15'd0, irq}, 16'h0000);
    @(negedge clk);
    rd_en = 1'b0;
    check_eq("mrst_strobe", rdata, 16'h0000);
    rst_n = 1'b1;

    rd_check("post_st",    8'h02, 16'h0000);
    rd_check("post_scr",   8'h10, 16'h0000);
    rd_check("post_wrcnt", 8'h04, 16'h0000);
    rd_check("post_id",    8'h00, 16'hA5C2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
